// File: rtl/trng_pkg.sv
// Shared constants and state encoding for the ring-oscillator entropy source
// and its sequencing controller.
package trng_pkg;

    localparam int unsigned WORD_W    = 32;
    localparam int unsigned NUM_RO    = 32;
    localparam int unsigned CTRL_W    = 5;
    localparam int unsigned BIT_CNT_W = $clog2(WORD_W);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_WARMUP  = 2'd1,
        ST_COLLECT = 2'd2,
        ST_FAULT   = 2'd3
    } trng_state_t;

endpackage

// File: rtl/trng_ctrl_if.sv
// Valid/ready port carrying assembled random words out of the controller.
interface trng_ctrl_if;
    import trng_pkg::*;

    logic [WORD_W-1:0] rnd_data;
    logic              rnd_valid;
    logic              rnd_ready;

    modport master (output rnd_data, output rnd_valid, input rnd_ready);
    modport slave  (input rnd_data, input rnd_valid, output rnd_ready);

endinterface

// File: rtl/trng_health_rct.sv
// Repetition-count health test: flags a run of REP_LIMIT identical samples.
module trng_health_rct #(
    parameter int unsigned REP_LIMIT = 16
) (
    input  logic clk,
    input  logic clear_n,
    input  logic sample,
    input  logic sample_bit,
    input  logic restart,
    output logic fail_c
);

    localparam int unsigned CNT_W = $clog2(REP_LIMIT + 1);

    logic [CNT_W-1:0] run_q, run_d;
    logic             prev_q, prev_d;

    // Run length of the current streak; 0 means no sample seen since restart.
    always_comb begin
        run_d  = run_q;
        prev_d = prev_q;
        if (restart) begin
            run_d  = '0;
            prev_d = 1'b0;
        end else if (sample) begin
            prev_d = sample_bit;
            if (run_q == '0 || sample_bit != prev_q) begin
                run_d = CNT_W'(1);
            end else if (run_q != CNT_W'(REP_LIMIT)) begin
                run_d = run_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            run_q  <= '0;
            prev_q <= 1'b0;
        end else begin
            run_q  <= run_d;
            prev_q <= prev_d;
        end
    end

    assign fail_c = (run_q == CNT_W'(REP_LIMIT));

endmodule

// File: rtl/trng_ctrl.sv
// Sequencing controller for the XOR-tree entropy source: warm-up, divided
// sampling, 32-bit word assembly with backpressure, and health shutdown.
module trng_ctrl
    import trng_pkg::*;
#(
    parameter int unsigned WARMUP_CYCLES = 256,
    parameter int unsigned SAMPLE_DIV    = 4,
    parameter int unsigned REP_LIMIT     = 16
) (
    input  logic              clk,
    input  logic              clear_n,
    input  logic              start,
    input  logic              stop,
    input  logic [NUM_RO-1:0] ro_mask,
    input  logic [CTRL_W-1:0] delay_sel,
    output logic [NUM_RO-1:0] ro_en,
    output logic [CTRL_W-1:0] ro_ctrl,
    output logic              tree_clear,
    input  logic              z,
    trng_ctrl_if.master       rnd,
    output logic              busy,
    output logic              fault,
    input  logic              fault_ack
);

    localparam int unsigned WARM_W = $clog2(WARMUP_CYCLES + 1);
    localparam int unsigned DIV_W  = $clog2(SAMPLE_DIV + 1);

    trng_state_t          state_q, state_d;
    logic [WARM_W-1:0]    warm_q, warm_d;
    logic [DIV_W-1:0]     div_q, div_d;
    logic [BIT_CNT_W-1:0] bit_q, bit_d;
    logic [WORD_W-1:0]    shift_q, shift_d;
    logic                 pend_q, pend_d;
    logic [NUM_RO-1:0]    ro_en_q, ro_en_d;
    logic [CTRL_W-1:0]    ro_ctrl_q, ro_ctrl_d;
    logic                 tree_clear_q, tree_clear_d;
    logic [WORD_W-1:0]    rnd_data_q, rnd_data_d;
    logic                 rnd_valid_q, rnd_valid_d;
    logic                 busy_q, busy_d;
    logic                 fault_q, fault_d;

    logic                 xfer_c;
    logic                 sample_c;
    logic                 restart_c;
    logic                 fail_c;
    logic [WORD_W-1:0]    word_c;

    assign xfer_c    = rnd_valid_q & rnd.rnd_ready;
    assign word_c    = {shift_q[WORD_W-2:0], z};
    assign restart_c = (state_d != ST_COLLECT);

    trng_health_rct #(
        .REP_LIMIT (REP_LIMIT)
    ) u_rct (
        .clk        (clk),
        .clear_n    (clear_n),
        .sample     (sample_c),
        .sample_bit (z),
        .restart    (restart_c),
        .fail_c     (fail_c)
    );

    always_comb begin
        state_d      = state_q;
        warm_d       = warm_q;
        div_d        = div_q;
        bit_d        = bit_q;
        shift_d      = shift_q;
        pend_d       = pend_q;
        ro_en_d      = ro_en_q;
        ro_ctrl_d    = ro_ctrl_q;
        tree_clear_d = tree_clear_q;
        rnd_data_d   = rnd_data_q;
        rnd_valid_d  = rnd_valid_q;
        fault_d      = fault_q;
        sample_c     = 1'b0;

        if (xfer_c) begin
            rnd_valid_d = 1'b0;
        end

        case (state_q)
            ST_IDLE: begin
                if (start && !stop && (ro_mask != '0)) begin
                    state_d   = ST_WARMUP;
                    ro_en_d   = ro_mask;
                    ro_ctrl_d = delay_sel;
                    warm_d    = '0;
                end
            end

            ST_WARMUP: begin
                if (stop) begin
                    state_d = ST_IDLE;
                    ro_en_d = '0;
                end else if (warm_q == WARM_W'(WARMUP_CYCLES - 1)) begin
                    state_d      = ST_COLLECT;
                    tree_clear_d = 1'b0;
                    div_d        = '0;
                    bit_d        = '0;
                    shift_d      = '0;
                    pend_d       = 1'b0;
                end else begin
                    warm_d = warm_q + WARM_W'(1);
                end
            end

            ST_COLLECT: begin
                // Health failure and stop both tear down the run and drop any partial word.
                if (fail_c || stop) begin
                    state_d      = fail_c ? ST_FAULT : ST_IDLE;
                    fault_d      = fail_c;
                    ro_en_d      = '0;
                    tree_clear_d = 1'b1;
                    rnd_valid_d  = 1'b0;
                    pend_d       = 1'b0;
                    bit_d        = '0;
                    shift_d      = '0;
                    div_d        = '0;
                end else if (pend_q) begin
                    if (!rnd_valid_q || xfer_c) begin
                        rnd_data_d  = shift_q;
                        rnd_valid_d = 1'b1;
                        pend_d      = 1'b0;
                    end
                end else if (div_q == DIV_W'(SAMPLE_DIV - 1)) begin
                    div_d    = '0;
                    sample_c = 1'b1;
                    shift_d  = word_c;
                    bit_d    = bit_q + BIT_CNT_W'(1);
                    if (bit_q == BIT_CNT_W'(WORD_W - 1)) begin
                        if (!rnd_valid_q || xfer_c) begin
                            rnd_data_d  = word_c;
                            rnd_valid_d = 1'b1;
                        end else begin
                            pend_d = 1'b1;
                        end
                    end
                end else begin
                    div_d = div_q + DIV_W'(1);
                end
            end

            ST_FAULT: begin
                if (fault_ack) begin
                    state_d = ST_IDLE;
                    fault_d = 1'b0;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clk or negedge clear_n) begin
        if (!clear_n) begin
            state_q      <= ST_IDLE;
            warm_q       <= '0;
            div_q        <= '0;
            bit_q        <= '0;
            shift_q      <= '0;
            pend_q       <= 1'b0;
            ro_en_q      <= '0;
            ro_ctrl_q    <= '0;
            tree_clear_q <= 1'b1;
            rnd_data_q   <= '0;
            rnd_valid_q  <= 1'b0;
            busy_q       <= 1'b0;
            fault_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            warm_q       <= warm_d;
            div_q        <= div_d;
            bit_q        <= bit_d;
            shift_q      <= shift_d;
            pend_q       <= pend_d;
            ro_en_q      <= ro_en_d;
            ro_ctrl_q    <= ro_ctrl_d;
            tree_clear_q <= tree_clear_d;
            rnd_data_q   <= rnd_data_d;
            rnd_valid_q  <= rnd_valid_d;
            busy_q       <= busy_d;
            fault_q      <= fault_d;
        end
    end

    assign ro_en         = ro_en_q;
    assign ro_ctrl       = ro_ctrl_q;
    assign tree_clear    = tree_clear_q;
    assign rnd.rnd_data  = rnd_data_q;
    assign rnd.rnd_valid = rnd_valid_q;
    assign busy          = busy_q;
    assign fault         = fault_q;

endmodule

// File: tb/tb_trng_ctrl.sv
// Self-checking bench for trng_ctrl: randomized source/consumer traffic
// compared each cycle against a timestamp/queue model of the sequencer.
module tb_trng_ctrl;
    import trng_pkg::*;

    localparam int unsigned W   = 256;
    localparam int unsigned D   = 4;
    localparam int unsigned REP = 16;

    logic        clk;
    logic        clear_n;
    logic        start;
    logic        stop;
    logic        z;
    logic        fault_ack;
    logic [31:0] ro_mask;
    logic [4:0]  delay_sel;
    logic [31:0] ro_en;
    logic [4:0]  ro_ctrl;
    logic        tree_clear;
    logic        busy;
    logic        fault;

    trng_ctrl_if bus ();

    trng_ctrl #(
        .WARMUP_CYCLES (W),
        .SAMPLE_DIV    (D),
        .REP_LIMIT     (REP)
    ) dut (
        .clk        (clk),
        .clear_n    (clear_n),
        .start      (start),
        .stop       (stop),
        .ro_mask    (ro_mask),
        .delay_sel  (delay_sel),
        .ro_en      (ro_en),
        .ro_ctrl    (ro_ctrl),
        .tree_clear (tree_clear),
        .z          (z),
        .rnd        (bus),
        .busy       (busy),
        .fault      (fault),
        .fault_ack  (fault_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_mis = 0;
    int edge_n = 0;
    int z_mode = 2;    // 0 random (no fault-length runs), 1 alternate per sample, 2 stuck at 0
    int rdy_mode = 0;  // 0 held by script, 1 random each cycle
    int ks;

    // Reference model: run start timestamp, next sample time, bits of the
    // word under assembly, one output slot and one waiting word.
    bit          m_run, m_fault, m_ov, m_pend, m_prev;
    logic [31:0] m_od, m_pw, m_mask;
    logic [4:0]  m_ctrl;
    int          m_ks, m_next, m_fail_edge, m_rep, m_nsamp;
    bit          m_bits[$];

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_mis++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (edge %0d)", tag, act, exp, edge_n);
        end
    endtask

    function automatic void model_reset();
        m_run = 0; m_fault = 0; m_ov = 0; m_pend = 0; m_prev = 0;
        m_od = '0; m_pw = '0; m_mask = '0; m_ctrl = '0;
        m_ks = 0; m_next = 0; m_fail_edge = -10; m_rep = 0; m_nsamp = 0;
        m_bits.delete();
    endfunction

    function automatic void model_step(input int e);
        logic [31:0] w;
        if (m_ov && bus.rnd_ready) m_ov = 0;
        if (m_fault) begin
            if (fault_ack) m_fault = 0;
        end else if (!m_run) begin
            if (start && !stop && ro_mask != 32'h0) begin
                m_run = 1; m_ks = e; m_mask = ro_mask; m_ctrl = delay_sel;
                m_next = e + int'(W) + int'(D);
                m_bits.delete(); m_rep = 0; m_nsamp = 0; m_pend = 0; m_fail_edge = -10;
            end
        end else if (e == m_fail_edge + 1) begin
            m_run = 0; m_fault = 1; m_ov = 0;
        end else if (stop) begin
            m_run = 0; m_ov = 0;
        end else if (m_pend) begin
            if (!m_ov) begin
                m_od = m_pw; m_ov = 1; m_pend = 0; m_next = e + int'(D);
            end
        end else if (e == m_next) begin
            m_nsamp++;
            if (m_rep == 0 || z != m_prev) m_rep = 1;
            else m_rep++;
            m_prev = z;
            if (m_rep == int'(REP)) m_fail_edge = e;
            m_bits.push_back(z);
            m_next = e + int'(D);
            if (m_bits.size() == 32) begin
                w = '0;
                foreach (m_bits[i]) w = {w[30:0], m_bits[i]};
                m_bits.delete();
                if (!m_ov) begin m_od = w; m_ov = 1; end
                else begin m_pw = w; m_pend = 1; end
            end
        end
    endfunction

    task automatic compare_all();
        check_val("ro_en", ro_en, m_run ? m_mask : 32'h0);
        check_val("ro_ctrl", 32'(ro_ctrl), 32'(m_ctrl));
        check_val("tree_clear", 32'(tree_clear), (m_run && edge_n >= m_ks + int'(W)) ? 32'd0 : 32'd1);
        check_val("busy", 32'(busy), 32'(m_run || m_fault));
        check_val("fault", 32'(fault), 32'(m_fault));
        check_val("rnd_valid", 32'(bus.rnd_valid), 32'(m_ov));
        if (m_ov) check_val("rnd_data", bus.rnd_data, m_od);
    endtask

    task automatic drive();
        case (z_mode)
            0: z = (m_run && m_rep >= int'(REP) - 1) ? ~m_prev : 1'($urandom_range(0, 1));
            1: z = (m_nsamp % 2 == 0);
            default: z = 1'b0;
        endcase
        if (rdy_mode == 1) bus.rnd_ready = 1'($urandom_range(0, 1));
    endtask

    task automatic tick();
        @(posedge clk);
        edge_n++;
        if (clear_n) model_step(edge_n);
        #1;
        if (clear_n) compare_all();
        drive();
    endtask

    task automatic check_reset_values(input string pfx);
        check_val({pfx, "_ro_en"}, ro_en, 32'h0);
        check_val({pfx, "_ro_ctrl"}, 32'(ro_ctrl), 32'h0);
        check_val({pfx, "_tree_clear"}, 32'(tree_clear), 32'h1);
        check_val({pfx, "_rnd_data"}, bus.rnd_data, 32'h0);
        check_val({pfx, "_rnd_valid"}, 32'(bus.rnd_valid), 32'h0);
        check_val({pfx, "_busy"}, 32'(busy), 32'h0);
        check_val({pfx, "_fault"}, 32'(fault), 32'h0);
    endtask

    task automatic wait_valid(input int budget);
        for (int i = 0; i < budget && bus.rnd_valid !== 1'b1; i++) tick();
    endtask

    initial begin
        clear_n = 0; start = 0; stop = 0; z = 0; fault_ack = 0;
        ro_mask = '0; delay_sel = '0; bus.rnd_ready = 0;
        model_reset();
        #13;
        check_reset_values("rst");
        @(negedge clk);
        clear_n = 1;
        repeat (3) tick();

        // start with an empty mask is ignored
        start = 1; ro_mask = 32'h0; tick(); start = 0;
        check_val("mask0_busy", 32'(busy), 32'h0);
        tick();

        // stop beats start in the same cycle
        start = 1; stop = 1; ro_mask = 32'h0000_00FF; delay_sel = 5'd3; tick();
        start = 0; stop = 0;
        check_val("startstop_busy", 32'(busy), 32'h0);

        // basic word with an alternating source
        bus.rnd_ready = 1; z_mode = 1;
        start = 1; tick(); start = 0; ks = m_ks;
        check_val("basic_ro_en", ro_en, 32'h0000_00FF);
        check_val("basic_ro_ctrl", 32'(ro_ctrl), 32'd3);
        wait_valid(600);
        check_val("basic_valid_seen", 32'(bus.rnd_valid), 32'h1);
        check_val("basic_latency", 32'(edge_n - ks), 32'(W + 32 * D));
        check_val("basic_word", bus.rnd_data, 32'hAAAA_AAAA);
        z_mode = 0;
        repeat (3 * 32 * D) tick();

        // backpressure: one word held at the output, the next held in the assembler
        bus.rnd_ready = 0;
        repeat (300) tick();
        check_val("bp_valid_held", 32'(bus.rnd_valid), 32'h1);
        bus.rnd_ready = 1; tick();
        check_val("bp_word2_valid", 32'(bus.rnd_valid), 32'h1);
        repeat (2 * 32 * D) tick();

        // random consumer
        rdy_mode = 1;
        repeat (1500) tick();
        rdy_mode = 0; bus.rnd_ready = 1;
        stop = 1; tick(); stop = 0;
        check_val("stop1_busy", 32'(busy), 32'h0);

        // stop after 20 samples, then a clean restart
        start = 1; ro_mask = $urandom | 32'h1; delay_sel = 5'($urandom); tick(); start = 0;
        for (int i = 0; i < 600 && m_bits.size() != 20; i++) tick();
        check_val("stop_bits_reached", 32'(m_bits.size()), 32'd20);
        stop = 1; tick(); stop = 0;
        check_val("stop_busy", 32'(busy), 32'h0);
        check_val("stop_valid", 32'(bus.rnd_valid), 32'h0);
        check_val("stop_ro_en", ro_en, 32'h0);
        start = 1; tick(); start = 0; ks = m_ks;
        wait_valid(600);
        check_val("restart_latency", 32'(edge_n - ks), 32'(W + 32 * D));
        check_val("restart_word", bus.rnd_data, m_od);
        stop = 1; tick(); stop = 0;

        // stuck source trips the repetition test
        z_mode = 2;
        start = 1; ro_mask = 32'h8000_0001; tick(); start = 0; ks = m_ks;
        for (int i = 0; i < 600 && fault !== 1'b1; i++) tick();
        check_val("stuck_fault", 32'(fault), 32'h1);
        check_val("stuck_latency", 32'(edge_n - ks), 32'(W + REP * D + 1));
        check_val("stuck_ro_en", ro_en, 32'h0);
        check_val("stuck_valid", 32'(bus.rnd_valid), 32'h0);
        check_val("stuck_tree_clear", 32'(tree_clear), 32'h1);
        start = 1; stop = 1; repeat (3) tick(); start = 0; stop = 0;
        check_val("fault_sticky", 32'(fault), 32'h1);
        fault_ack = 1; tick(); fault_ack = 0;
        check_val("ack_busy", 32'(busy), 32'h0);
        check_val("ack_fault", 32'(fault), 32'h0);

        // asynchronous reset in the middle of collection
        z_mode = 0;
        start = 1; ro_mask = 32'hFFFF_FFFF; delay_sel = 5'h1F; tick(); start = 0;
        repeat (W + 50) tick();
        check_val("pre_areset_tree_clear", 32'(tree_clear), 32'h0);
        #2 clear_n = 0;
        #1;
        check_reset_values("areset");
        model_reset();
        tick();
        clear_n = 1;
        repeat (2) tick();
        check_val("post_areset_busy", 32'(busy), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
